// File: rtl/jstepclk.sv
// jstepclk: four-phase CPU clock generator with one-hot stepper.
// Free-run, single-step and restart control; outputs decoded from state.
module jstepclk #(
  parameter  int NSTEPS = 6,
  parameter  int DIV    = 1,
  localparam int SW     = $clog2(NSTEPS),
  localparam int DW     = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step_req,
  input  logic             restart,
  output logic             wclk,
  output logic             wclkd,
  output logic             wclke,
  output logic             wclks,
  output logic [0:NSTEPS-1] bos,
  output logic [SW-1:0]    step_idx,
  output logic             wrap,
  output logic             busy
);

  logic [DW-1:0] div_cnt;
  logic [1:0]    phase;
  logic [SW-1:0] step;
  logic          pend;
  logic          single;
  logic          wrap_q;

  logic active;
  logic at_div;
  logic bnd;
  logic to_zero;

  // Activity, quarter-phase tick, cycle boundary and stepper wrap decision
  always_comb begin
    active  = run | single | (phase != 2'd0) | (div_cnt != '0);
    at_div  = (div_cnt == DW'(DIV - 1));
    bnd     = active & at_div & (phase == 2'd3);
    to_zero = pend | restart | (step == SW'(NSTEPS - 1));
  end

  // Divider, phase, stepper and control flags
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      phase   <= 2'd0;
      step    <= '0;
      pend    <= 1'b0;
      single  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (active) begin
        if (at_div) begin
          div_cnt <= '0;
          phase   <= phase + 2'd1;
        end else begin
          div_cnt <= div_cnt + DW'(1);
        end
        if (bnd) begin
          step   <= to_zero ? '0 : step + SW'(1);
          wrap_q <= to_zero;
          pend   <= 1'b0;
          single <= 1'b0;
        end else if (restart) begin
          pend <= 1'b1;
        end
      end else begin
        if (restart)
          step <= '0;
        if (step_req && !run)
          single <= 1'b1;
      end
    end
  end

  // Clock window decode from phase
  always_comb begin
    wclk  = ~phase[1];
    wclkd = phase[1] ^ phase[0];
    wclke = (phase != 2'd3);
    wclks = (phase == 2'd1);
  end

  // One-hot stepper decode
  always_comb begin
    bos       = '0;
    bos[step] = 1'b1;
  end

  assign step_idx = step;
  assign wrap     = wrap_q;
  assign busy     = active;

endmodule

// File: tb/tb_jstepclk.sv
// tb_jstepclk: random stimulus against a cycle-position reference model.
// Model tracks clk position inside a CPU cycle rather than phase/divider.
module tb_jstepclk;

  localparam int NSTEPS = 6;
  localparam int DIV    = 2;
  localparam int CYC    = 4 * DIV;
  localparam int SW     = $clog2(NSTEPS);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic run = 1'b0;
  logic step_req = 1'b0;
  logic restart = 1'b0;
  logic wclk, wclkd, wclke, wclks;
  logic [0:NSTEPS-1] bos;
  logic [SW-1:0] step_idx;
  logic wrap, busy;

  int n_chk = 0;
  int n_bad = 0;

  int m_pos;
  int m_step;
  bit m_pend;
  bit m_single;
  bit m_wrap;

  always #5 clk = ~clk;

  jstepclk #(.NSTEPS(NSTEPS), .DIV(DIV)) dut (
    .clk(clk), .reset(reset), .run(run),
    .step_req(step_req), .restart(restart),
    .wclk(wclk), .wclkd(wclkd), .wclke(wclke), .wclks(wclks),
    .bos(bos), .step_idx(step_idx), .wrap(wrap), .busy(busy)
  );

  task automatic chk(input string tag,
                     input int unsigned got,
                     input int unsigned exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit act;
    act = run | m_single | (m_pos != 0);
    m_wrap = 1'b0;
    if (reset) begin
      m_pos = 0; m_step = 0; m_pend = 0; m_single = 0;
    end else if (act) begin
      if (m_pos == CYC - 1) begin
        m_pos = 0;
        if (m_pend || restart || m_step == NSTEPS - 1) begin
          m_step = 0;
          m_wrap = 1'b1;
        end else begin
          m_step = m_step + 1;
        end
        m_pend = 0;
        m_single = 0;
      end else begin
        m_pos = m_pos + 1;
        if (restart) m_pend = 1;
      end
    end else begin
      if (restart) m_step = 0;
      if (step_req && !run) m_single = 1;
    end
  endtask

  task automatic compare();
    int p;
    p = m_pos / DIV;
    chk("wclk",  32'(wclk),  32'(p < 2));
    chk("wclkd", 32'(wclkd), 32'(p == 1 || p == 2));
    chk("wclke", 32'(wclke), 32'(p < 3));
    chk("wclks", 32'(wclks), 32'(p == 1));
    chk("bos",   32'(bos),   32'(1) << (NSTEPS - 1 - m_step));
    chk("step_idx", 32'(step_idx), 32'(m_step));
    chk("wrap",  32'(wrap),  32'(m_wrap));
    chk("busy",  32'(busy),
        32'(run | m_single | (m_pos != 0)));
  endtask

  initial begin
    m_pos = 0; m_step = 0; m_pend = 0; m_single = 0; m_wrap = 0;
    repeat (2) begin
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      model_edge();
      #1 compare();
    end
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (i < 60) begin
        reset = 1'b0; run = 1'b1; step_req = 1'b0; restart = 1'b0;
      end else begin
        reset    = ($urandom_range(0, 199) == 0);
        if ($urandom_range(0, 39) == 0) run = ~run;
        step_req = ($urandom_range(0, 9) == 0);
        restart  = ($urandom_range(0, 29) == 0);
      end
      @(posedge clk);
      model_edge();
      #1 compare();
    end
    $display("%0d/%0d checks passed", n_chk - n_bad, n_chk);
    $finish;
  end

endmodule
